fpaddsub_seq: RTL



---
 rtl/fpaddsub_pkg.sv | 44 ++++
 rtl/fpaddsub_seq_lzc.sv | 22 ++
 rtl/fpaddsub_seq.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpaddsub_pkg.sv
// Shared types and width helpers for the multi-cycle floating-point adder/subtractor.
//   state_t     : sequencer states, one pipeline step per state
//   op_class_t  : operand classification after unpacking
//   total_w     : packed operand width {sign, exp, man}
//   align_w     : aligned mantissa field {1.man, G, R, S}
//   sum_w       : adder width (aligned field plus carry)
//   FLAG_*      : bit positions inside the optional flags output
package fpaddsub_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        UNPACK = 3'd1,
        ALIGN  = 3'd2,
        ADD    = 3'd3,
        NORM   = 3'd4,
        ROUND  = 3'd5,
        DONE   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        ZERO   = 2'd0,
        NORMAL = 2'd1,
        INF    = 2'd2,
        NAN    = 2'd3
    } op_class_t;

    function automatic int total_w(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

    function automatic int align_w(input int man_w);
        return man_w + 4;
    endfunction

    function automatic int sum_w(input int man_w);
        return man_w + 5;
    endfunction

    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

endpackage

// File: rtl/fpaddsub_seq_lzc.sv
// fp_lzc: combinational leading-zero counter.
//   din   : W-bit input vector
//   count : number of zeros above the most significant set bit (W when din is 0)
module fp_lzc
    import fpaddsub_pkg::*;
#(
    parameter int W  = 28,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  din,
    output logic [CW-1:0] count
);

    // Scan upward; the highest set bit is the last one to write the count.
    always_comb begin
        count = CW'(W);
        for (int i = 0; i < W; i++) begin
            count = din[i] ? CW'(W - 1 - i) : count;
        end
    end

endmodule

// File: rtl/fpaddsub_seq.sv
// fpaddsub_seq: parametrised multi-cycle floating-point adder/subtractor with
// round-to-nearest-even and valid/ready handshakes on both sides.
//   clk, reset          : clock, asynchronous active-high reset
//   in_valid / in_ready : operand handshake (accepted only in IDLE)
//   dataa, datab, sub   : operands {sign, exp, man}; sub=1 computes A - B
//   out_valid/out_ready : result handshake, result held until taken
//   result              : rounded sum/difference
//   flags               : {invalid, overflow, underflow, inexact}, present only
//                         when FPADDSUB_FLAGS_EN is defined
// Subnormal operands are treated as signed zero, and results that would be
// subnormal are flushed to signed zero.
module fpaddsub_seq
    import fpaddsub_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [EXP_W+MAN_W:0] dataa,
    input  logic [EXP_W+MAN_W:0] datab,
    input  logic               sub,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [EXP_W+MAN_W:0] result
`ifdef FPADDSUB_FLAGS_EN
    ,
    output logic [3:0]         flags
`endif
);

    localparam int W  = total_w(EXP_W, MAN_W);
    localparam int AW = align_w(MAN_W);
    localparam int SW = sum_w(MAN_W);
    localparam int CW = $clog2(SW + 1);
    localparam int XW = EXP_W + 1;

    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    function automatic op_class_t classify(input logic [W-2:0] v);
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m;
        e = v[W-2:MAN_W];
        m = v[MAN_W-1:0];
        if (e == '0)      return ZERO;
        else if (e == '1) return (m == '0) ? INF : NAN;
        else              return NORMAL;
    endfunction

    state_t           state_r, state_nx_s;
    logic             in_ready_r, out_valid_r;
    logic [W-1:0]     a_r, b_r, result_r;
    logic             x_sign_r, eff_sub_r;
    logic [EXP_W-1:0] x_exp_r, y_exp_r;
    logic [MAN_W:0]   x_man_r, y_man_r;
    logic             special_r, invalid_r;
    logic [W-1:0]     special_res_r;
    logic [AW-1:0]    yf_r, norm_man_r;
    logic [SW-1:0]    sum_r;
    logic [XW-1:0]    norm_exp_r;
    logic             norm_zero_r, norm_flush_r;

    // UNPACK signals
    op_class_t        cls_a_s, cls_b_s;
    logic             a_ge_s, spec_s, inv_s;
    logic [W-1:0]     spec_res_s;
    // ALIGN / ADD / NORM / ROUND signals
    logic [EXP_W-1:0] diff_s;
    logic [AW-1:0]    yfield_s, ymask_s, yf_s, xf_s;
    logic [SW-1:0]    sum_s;
    logic [CW-1:0]    lz_s, sh_s;
    logic [AW-1:0]    nm_s;
    logic [XW-1:0]    ne_s, rexp_s;
    logic             flush_s, inc_s, carry_s, ovf_s;
    logic [MAN_W+1:0] rm_s;
    logic [MAN_W-1:0] frac_s;
    logic [W-1:0]     res_s;
    logic [3:0]       flags_s;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;

    // Sequencer next state: one step per state, DONE waits for the consumer.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE:    if (in_valid) state_nx_s = UNPACK; else state_nx_s = IDLE;
            UNPACK:  state_nx_s = ALIGN;
            ALIGN:   state_nx_s = ADD;
            ADD:     state_nx_s = NORM;
            NORM:    state_nx_s = ROUND;
            ROUND:   state_nx_s = DONE;
            DONE:    if (out_ready) state_nx_s = IDLE; else state_nx_s = DONE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Sequencer state and registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            in_ready_r  <= (state_nx_s == IDLE);
            out_valid_r <= (state_nx_s == DONE);
        end
    end

    // Operand classification, special-case results and magnitude ordering.
    always_comb begin
        cls_a_s    = classify(a_r[W-2:0]);
        cls_b_s    = classify(b_r[W-2:0]);
        a_ge_s     = (a_r[W-2:0] >= b_r[W-2:0]);
        spec_s     = 1'b1;
        inv_s      = 1'b0;
        spec_res_s = '0;
        if (cls_a_s == NAN || cls_b_s == NAN ||
            (cls_a_s == INF && cls_b_s == INF && a_r[W-1] != b_r[W-1])) begin
            spec_res_s = QNAN;
            inv_s      = 1'b1;
        end else if (cls_a_s == INF) begin
            spec_res_s = a_r;
        end else if (cls_b_s == INF) begin
            spec_res_s = b_r;
        end else if (cls_a_s == ZERO && cls_b_s == ZERO) begin
            // Only (-0)+(-0) keeps a negative sign.
            spec_res_s = {a_r[W-1] & b_r[W-1], {(W-1){1'b0}}};
        end else if (cls_a_s == ZERO) begin
            spec_res_s = b_r;
        end else if (cls_b_s == ZERO) begin
            spec_res_s = a_r;
        end else begin
            spec_s = 1'b0;
        end
    end

    // Alignment of the smaller operand and the add/subtract itself.
    always_comb begin
        diff_s   = x_exp_r - y_exp_r;
        yfield_s = {y_man_r, 3'b000};
        ymask_s  = ~({AW{1'b1}} << diff_s);
        if (32'(diff_s) >= 32'(MAN_W + 3)) begin
            // Nothing but the sticky bit survives the shift.
            yf_s = {{(AW-1){1'b0}}, 1'b1};
        end else begin
            yf_s = (yfield_s >> diff_s) | {{(AW-1){1'b0}}, |(yfield_s & ymask_s)};
        end
        xf_s = {x_man_r, 3'b000};
        if (eff_sub_r) sum_s = {1'b0, xf_s} - {1'b0, yf_r};
        else           sum_s = {1'b0, xf_s} + {1'b0, yf_r};
    end

    fp_lzc #(.W(SW), .CW(CW)) u_lzc (
        .din   (sum_r),
        .count (lz_s)
    );

    // Normalisation: the top bit of the sum is the carry slot, so a sum
    // without carry is shifted left by one less than its leading-zero count.
    always_comb begin
        sh_s = lz_s - CW'(1);
        if (sum_r[SW-1]) begin
            nm_s    = {sum_r[SW-1:2], |sum_r[1:0]};
            ne_s    = {1'b0, x_exp_r} + XW'(1);
            flush_s = 1'b0;
        end else begin
            nm_s    = AW'(sum_r << sh_s);
            ne_s    = {1'b0, x_exp_r} - XW'(sh_s);
            flush_s = (32'(sh_s) >= 32'(x_exp_r));
        end
    end

    // Round-to-nearest-even, range checks and final packing.
    always_comb begin
        inc_s   = nm_s_g() & (norm_man_r[1] | norm_man_r[0] | norm_man_r[3]);
        rm_s    = {1'b0, norm_man_r[AW-1:3]} + {{(MAN_W+1){1'b0}}, inc_s};
        carry_s = rm_s[MAN_W+1];
        frac_s  = carry_s ? rm_s[MAN_W:1] : rm_s[MAN_W-1:0];
        rexp_s  = norm_exp_r + {{EXP_W{1'b0}}, carry_s};
        ovf_s   = (rexp_s >= {1'b0, {EXP_W{1'b1}}});
        flags_s = 4'b0000;
        if (special_r) begin
            res_s                 = special_res_r;
            flags_s[FLAG_INVALID] = invalid_r;
        end else if (norm_zero_r) begin
            res_s = '0;
        end else if (norm_flush_r) begin
            res_s                   = {x_sign_r, {(W-1){1'b0}}};
            flags_s[FLAG_UNDERFLOW] = 1'b1;
            flags_s[FLAG_INEXACT]   = 1'b1;
        end else if (ovf_s) begin
            res_s                  = {x_sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_s[FLAG_OVERFLOW] = 1'b1;
            flags_s[FLAG_INEXACT]  = 1'b1;
        end else begin
            res_s                 = {x_sign_r, rexp_s[EXP_W-1:0], frac_s};
            flags_s[FLAG_INEXACT] = |norm_man_r[2:0];
        end
    end

    function automatic logic nm_s_g();
        return norm_man_r[2];
    endfunction

    // Per-stage datapath registers, each loaded only in its own state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_r           <= '0;
            b_r           <= '0;
            x_sign_r      <= 1'b0;
            eff_sub_r     <= 1'b0;
            x_exp_r       <= '0;
            y_exp_r       <= '0;
            x_man_r       <= '0;
            y_man_r       <= '0;
            special_r     <= 1'b0;
            invalid_r     <= 1'b0;
            special_res_r <= '0;
            yf_r          <= '0;
            sum_r         <= '0;
            norm_man_r    <= '0;
            norm_exp_r    <= '0;
            norm_zero_r   <= 1'b0;
            norm_flush_r  <= 1'b0;
            result_r      <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        a_r <= dataa;
                        b_r <= {datab[W-1] ^ sub, datab[W-2:0]};
                    end
                end
                UNPACK: begin
                    special_r     <= spec_s;
                    invalid_r     <= inv_s;
                    special_res_r <= spec_res_s;
                    eff_sub_r     <= a_r[W-1] ^ b_r[W-1];
                    x_sign_r      <= a_ge_s ? a_r[W-1] : b_r[W-1];
                    x_exp_r       <= a_ge_s ? a_r[W-2:MAN_W] : b_r[W-2:MAN_W];
                    y_exp_r       <= a_ge_s ? b_r[W-2:MAN_W] : a_r[W-2:MAN_W];
                    x_man_r       <= {1'b1, a_ge_s ? a_r[MAN_W-1:0] : b_r[MAN_W-1:0]};
                    y_man_r       <= {1'b1, a_ge_s ? b_r[MAN_W-1:0] : a_r[MAN_W-1:0]};
                end
                ALIGN: yf_r <= yf_s;
                ADD:   sum_r <= sum_s;
                NORM: begin
                    norm_man_r   <= nm_s;
                    norm_exp_r   <= ne_s;
                    norm_zero_r  <= (sum_r == '0);
                    norm_flush_r <= flush_s;
                end
                ROUND:   result_r <= res_s;
                default: result_r <= result_r;
            endcase
        end
    end

`ifdef FPADDSUB_FLAGS_EN
    logic [3:0] flags_r;
    assign flags = flags_r;

    // Status flags travel with the result register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                 flags_r <= 4'b0000;
        else if (state_r == ROUND) flags_r <= flags_s;
        else                       flags_r <= flags_r;
    end
`endif

endmodule
